// File: rtl/nd_2to1_pkg.sv
// Shared types and constants for the nd_2to1 merge node.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nd_2to1_pkg;

    localparam int NS_ADDRESS_SIZE = 32;
    localparam int NS_DATA_SIZE    = 32;

    // Output side state: idle (may load a new head) or busy (waiting for the sink's ack toggle).
    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_t;

    // Input selector, also used to remember the last granted input.
    typedef enum logic {
        SEL_RCV0 = 1'b0,
        SEL_RCV1 = 1'b1
    } sel_t;

    // Two-phase handshakes advance by flipping the req/ack level.
    function automatic logic ns_bit_toggle(input logic b);
        return ~b;
    endfunction

endpackage

// File: rtl/nd_2to1_if.sv
// Two-phase toggle channels of the merge node: two inbound (rcv0, rcv1), one outbound (snd0).
// Latency: n/a (wiring only).
// Backpressure: a message is pending while req != ack; data is held until the ack level matches.
interface nd_2to1_if #(
    parameter int DSZ = nd_2to1_pkg::NS_DATA_SIZE
);
    logic           rcv0_req;
    logic           rcv0_ack;
    logic [DSZ-1:0] rcv0_dat;
    logic           rcv1_req;
    logic           rcv1_ack;
    logic [DSZ-1:0] rcv1_dat;
    logic           snd0_req;
    logic           snd0_ack;
    logic [DSZ-1:0] snd0_dat;

    // The merge node itself.
    modport slave (
        input  rcv0_req, rcv0_dat, rcv1_req, rcv1_dat, snd0_ack,
        output rcv0_ack, rcv1_ack, snd0_req, snd0_dat
    );

    // The surrounding peers: both sources and the sink.
    modport master (
        output rcv0_req, rcv0_dat, rcv1_req, rcv1_dat, snd0_ack,
        input  rcv0_ack, rcv1_ack, snd0_req, snd0_dat
    );
endinterface

// File: rtl/nd_2to1_fifo.sv
// Single-clock FIFO of 2**FIFO_LG2 entries between the arbiter and the output state machine.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: push is ignored while full (registered pointers), pop is ignored while empty.
module nd_2to1_fifo #(
    parameter int DSZ      = 32,
    parameter int FIFO_LG2 = 1
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           push,
    input  logic [DSZ-1:0] push_dat,
    input  logic           pop,
    output logic [DSZ-1:0] pop_dat,
    output logic           full,
    output logic           empty
);
    localparam int PW    = FIFO_LG2 + 1;
    localparam int IW    = (FIFO_LG2 > 0) ? FIFO_LG2 : 1;
    localparam int DEPTH = 1 << FIFO_LG2;
    // Pointer XOR pattern meaning "MSBs differ, index bits equal".
    localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [DSZ-1:0] mem [0:(1 << IW)-1];
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic           do_push;
    logic           do_pop;

    assign wr_idx  = wr_ptr[IW-1:0];
    assign rd_idx  = rd_ptr[IW-1:0];
    assign full    = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_idx];

    // Storage is not reset: the pointers alone decide what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_dat;
        end
    end

    // Pointers wrap naturally; a reset discards everything buffered.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end
endmodule

// File: rtl/nd_2to1.sv
// Merge node: joins rcv0/rcv1 toggle channels into snd0 with fair round-robin and a small FIFO.
// Latency: req edge sampled at edge n is acked at n+2; output loads one cycle after the FIFO write.
// Backpressure: inputs are not acked while the FIFO is full; snd0 holds data until its ack toggles.
module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int FIFO_LG2 = 1
) (
    input  logic       i_clk,
    input  logic       reset,
    output logic       ready,
    nd_2to1_if.slave   ch
);
    // The address width only exists so this node drops in wherever its siblings do.
    if (ASZ < 1) begin : g_no_addr
    end

    logic [1:0]     req0_sync;
    logic [1:0]     req1_sync;
    logic [1:0]     ack_sync;
    logic [1:0]     ready_sr;
    logic           s_req0;
    logic           s_req1;
    logic           s_ack;
    logic           pend0;
    logic           pend1;
    logic           take;
    sel_t           take_sel;
    sel_t           rr_last;
    logic [DSZ-1:0] take_dat;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [DSZ-1:0] fifo_head;
    out_state_t     out_state;

    assign s_req0 = req0_sync[1];
    assign s_req1 = req1_sync[1];
    assign s_ack  = ack_sync[1];
    assign ready  = ready_sr[1];

    // Two-flop synchronisers for every level that comes from another clock domain.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            req0_sync <= '0;
            req1_sync <= '0;
            ack_sync  <= '0;
        end else begin
            req0_sync <= {req0_sync[0], ch.rcv0_req};
            req1_sync <= {req1_sync[0], ch.rcv1_req};
            ack_sync  <= {ack_sync[0], ch.snd0_ack};
        end
    end

    // Ready rises once both synchroniser stages hold post-reset samples.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready_sr <= '0;
        end else begin
            ready_sr <= {ready_sr[0], 1'b1};
        end
    end

    assign pend0 = s_req0 ^ ch.rcv0_ack;
    assign pend1 = s_req1 ^ ch.rcv1_ack;

    // Grant at most one input per cycle; on contention the one not served last wins.
    always_comb begin
        take     = 1'b0;
        take_sel = SEL_RCV0;
        if (ready && !fifo_full) begin
            if (pend0 && pend1) begin
                take     = 1'b1;
                take_sel = (rr_last == SEL_RCV0) ? SEL_RCV1 : SEL_RCV0;
            end else if (pend0) begin
                take     = 1'b1;
                take_sel = SEL_RCV0;
            end else if (pend1) begin
                take     = 1'b1;
                take_sel = SEL_RCV1;
            end
        end
    end

    assign take_dat = (take_sel == SEL_RCV1) ? ch.rcv1_dat : ch.rcv0_dat;

    // Acknowledge the granted input in the same edge its data is written into the FIFO.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ch.rcv0_ack <= 1'b0;
            ch.rcv1_ack <= 1'b0;
            rr_last     <= SEL_RCV1;
        end else if (take) begin
            rr_last <= take_sel;
            if (take_sel == SEL_RCV1) begin
                ch.rcv1_ack <= ns_bit_toggle(ch.rcv1_ack);
            end else begin
                ch.rcv0_ack <= ns_bit_toggle(ch.rcv0_ack);
            end
        end
    end

    assign fifo_pop = (out_state == OUT_IDLE) && !fifo_empty;

    nd_2to1_fifo #(
        .DSZ      (DSZ),
        .FIFO_LG2 (FIFO_LG2)
    ) u_fifo (
        .i_clk    (i_clk),
        .reset    (reset),
        .push     (take),
        .push_dat (take_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Output FSM: present the head and toggle req, then wait for the matching ack level.
    // The ack is only observed in BUSY, so a new head always waits one extra cycle in IDLE.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            out_state   <= OUT_IDLE;
            ch.snd0_req <= 1'b0;
            ch.snd0_dat <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (!fifo_empty) begin
                        ch.snd0_dat <= fifo_head;
                        ch.snd0_req <= ns_bit_toggle(ch.snd0_req);
                        out_state   <= OUT_BUSY;
                    end
                end
                OUT_BUSY: begin
                    if (s_ack == ch.snd0_req) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: directed vector table plus multi-cycle corner sequences.
// Latency: source acks are expected 3 peer ticks after the req toggle (2 sync edges + capture edge).
// Backpressure: the sink can be held off to fill the node, then released.
module tb_nd_2to1;
    localparam int DSZ      = 16;
    localparam int FIFO_LG2 = 1;

    typedef struct {
        int             grp;
        int             src;
        logic [DSZ-1:0] dat;
        logic [DSZ-1:0] exp_out;
    } vec_t;

    logic i_clk   = 1'b0;
    logic p_clk   = 1'b0;
    logic reset   = 1'b1;
    logic ready;

    nd_2to1_if #(.DSZ(DSZ)) ch ();

    nd_2to1 #(
        .DSZ      (DSZ),
        .FIFO_LG2 (FIFO_LG2)
    ) dut (
        .i_clk (i_clk),
        .reset (reset),
        .ready (ready),
        .ch    (ch)
    );

    always #4 i_clk = ~i_clk;
    always #7 p_clk = ~p_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Peer-side state, owned by the peer process except where the main sequence resets it.
    logic           use_slow  = 1'b0;
    logic           peer_rst  = 1'b1;
    logic           sink_hold = 1'b0;
    logic           busy0     = 1'b0;
    logic           busy1     = 1'b0;
    int             req_cyc0  = 0;
    int             done0     = 0;
    int             done1     = 0;
    int             lat_q[$];
    logic [DSZ-1:0] src0_q[$];
    logic [DSZ-1:0] src1_q[$];
    logic [DSZ-1:0] out_q[$];
    logic [DSZ-1:0] exp0_q[$];
    logic [DSZ-1:0] exp1_q[$];
    vec_t           vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Two sources and one sink, all ticking on the peer clock, 2 time units after its edge.
    initial begin
        ch.rcv0_req = 1'b0;
        ch.rcv1_req = 1'b0;
        ch.rcv0_dat = '0;
        ch.rcv1_dat = '0;
        ch.snd0_ack = 1'b0;
        forever begin
            if (use_slow) @(posedge p_clk);
            else          @(posedge i_clk);
            #2;
            if (peer_rst) begin
                ch.rcv0_req = 1'b0;
                ch.rcv1_req = 1'b0;
                ch.snd0_ack = 1'b0;
                busy0 = 1'b0;
                busy1 = 1'b0;
                src0_q.delete();
                src1_q.delete();
            end else begin
                if (busy0 && ch.rcv0_ack == ch.rcv0_req) begin
                    busy0 = 1'b0;
                    done0++;
                    if (!use_slow) lat_q.push_back(cyc - req_cyc0);
                end
                if (!busy0 && src0_q.size() > 0) begin
                    ch.rcv0_dat = src0_q.pop_front();
                    ch.rcv0_req = ~ch.rcv0_req;
                    busy0 = 1'b1;
                    req_cyc0 = cyc;
                end
                if (busy1 && ch.rcv1_ack == ch.rcv1_req) begin
                    busy1 = 1'b0;
                    done1++;
                end
                if (!busy1 && src1_q.size() > 0) begin
                    ch.rcv1_dat = src1_q.pop_front();
                    ch.rcv1_req = ~ch.rcv1_req;
                    busy1 = 1'b1;
                end
                if (!sink_hold && ch.snd0_req != ch.snd0_ack) begin
                    out_q.push_back(ch.snd0_dat);
                    ch.snd0_ack = ch.snd0_req;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        peer_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        reset = 1'b0;
        peer_rst = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check(name, out_q.size(), n);
    endtask

    task automatic push_group(input int g);
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                if (vecs[i].src == 0) src0_q.push_back(vecs[i].dat);
                else                  src1_q.push_back(vecs[i].dat);
            end
        end
    endtask

    task automatic check_group(input int g);
        int idx = 0;
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                check($sformatf("g%0d_out%0d", g, idx),
                      (idx < out_q.size()) ? 32'(out_q[idx]) : 32'hDEAD_BEEF,
                      32'(vecs[i].exp_out));
                idx++;
            end
        end
    endtask

    initial begin
        logic [DSZ-1:0] d;
        // grp 2: single input; grp 3: contention; grp 4: backpressure (sink held first).
        vecs = '{
            '{2, 0, 16'd5,  16'd5},  '{2, 0, 16'd9,  16'd9},  '{2, 0, 16'd2,  16'd2},
            '{3, 0, 16'd1,  16'd1},  '{3, 1, 16'd11, 16'd11}, '{3, 0, 16'd2,  16'd2},
            '{3, 1, 16'd12, 16'd12}, '{3, 0, 16'd3,  16'd3},  '{3, 1, 16'd13, 16'd13},
            '{3, 0, 16'd4,  16'd4},  '{3, 1, 16'd14, 16'd14},
            '{4, 0, 16'd21, 16'd21}, '{4, 1, 16'd31, 16'd31}, '{4, 0, 16'd22, 16'd22},
            '{4, 1, 16'd32, 16'd32}, '{4, 0, 16'd23, 16'd23}, '{4, 1, 16'd33, 16'd33}
        };

        // 1: reset values, then ready two cycles after release.
        reset = 1'b1;
        peer_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_rcv0_ack", ch.rcv0_ack, 0);
        check("rst_rcv1_ack", ch.rcv1_ack, 0);
        check("rst_snd0_req", ch.snd0_req, 0);
        check("rst_snd0_dat", ch.snd0_dat, 0);
        check("rst_ready",    ready,       0);
        reset = 1'b0;
        peer_rst = 1'b0;
        @(negedge i_clk);
        check("ready_1cyc", ready, 0);
        @(negedge i_clk);
        check("ready_2cyc", ready, 1);
        repeat (2) @(negedge i_clk);

        // 2: single input, in order, ack 3 peer ticks after the req toggle.
        out_q.delete();
        lat_q.delete();
        push_group(2);
        wait_out(3, 300, "g2_count");
        check_group(2);
        repeat (6) @(negedge i_clk);
        check("g2_lat_count", lat_q.size(), 3);
        foreach (lat_q[i]) check($sformatf("g2_ack_lat%0d", i), lat_q[i], 3);

        // 3: both inputs contend; round robin interleaves them starting with rcv0.
        do_reset();
        out_q.delete();
        push_group(3);
        wait_out(8, 600, "g3_count");
        check_group(3);

        // 4: sink stalls; only output register + 2 FIFO slots get acked, then all drain in order.
        do_reset();
        out_q.delete();
        done0 = 0;
        done1 = 0;
        sink_hold = 1'b1;
        push_group(4);
        repeat (60) @(negedge i_clk);
        check("g4_acks_rcv0", done0, 2);
        check("g4_acks_rcv1", done1, 1);
        check("g4_out_pending", ch.snd0_req ^ ch.snd0_ack, 1);
        check("g4_out_dat", ch.snd0_dat, 21);
        check("g4_none_out", out_q.size(), 0);
        sink_hold = 1'b0;
        wait_out(6, 600, "g4_count");
        check_group(4);

        // 5: reset while busy with two queued entries; nothing stale comes out afterwards.
        do_reset();
        out_q.delete();
        done0 = 0;
        done1 = 0;
        sink_hold = 1'b1;
        src0_q.push_back(16'd41);
        src0_q.push_back(16'd42);
        src1_q.push_back(16'd51);
        repeat (40) @(negedge i_clk);
        check("g5_acks_before", done0 + done1, 3);
        check("g5_busy_before", ch.snd0_req ^ ch.snd0_ack, 1);
        reset = 1'b1;
        peer_rst = 1'b1;
        sink_hold = 1'b0;
        repeat (3) @(negedge i_clk);
        check("g5_snd0_req", ch.snd0_req, 0);
        check("g5_snd0_dat", ch.snd0_dat, 0);
        check("g5_fifo_empty", dut.fifo_empty, 1);
        reset = 1'b0;
        peer_rst = 1'b0;
        out_q.delete();
        repeat (40) @(negedge i_clk);
        check("g5_no_stale", out_q.size(), 0);
        src0_q.push_back(16'd77);
        wait_out(1, 200, "g5_fresh_count");
        check("g5_fresh_dat", (out_q.size() > 0) ? 32'(out_q[0]) : 32'hDEAD_BEEF, 77);

        // 6: peers on a slower unrelated clock, 200 random messages tagged by source in the MSB.
        do_reset();
        out_q.delete();
        use_slow = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = {1'b0, 15'($urandom)};
            src0_q.push_back(d);
            exp0_q.push_back(d);
            d = {1'b1, 15'($urandom)};
            src1_q.push_back(d);
            exp1_q.push_back(d);
        end
        wait_out(200, 20000, "g6_count");
        repeat (50) @(negedge i_clk);
        check("g6_no_dup", out_q.size(), 200);
        foreach (out_q[i]) begin
            if (out_q[i][DSZ-1] == 1'b0) begin
                check($sformatf("g6_rcv0_%0d", i), out_q[i],
                      (exp0_q.size() > 0) ? 32'(exp0_q.pop_front()) : 32'hDEAD_BEEF);
            end else begin
                check($sformatf("g6_rcv1_%0d", i), out_q[i],
                      (exp1_q.size() > 0) ? 32'(exp1_q.pop_front()) : 32'hDEAD_BEEF);
            end
        end
        check("g6_rcv0_left", exp0_q.size(), 0);
        check("g6_rcv1_left", exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
